conv_column_feeder: RTL and testbench

Producer side of the 3-row column stream consumed by the 3x3 systolic convolution array. It accepts a raster-order pixel stream one pixel per cycle and holds the two previous image rows in line buffers. For every pixel of row 2 onward, it emits one vertical 3-pixel column on `input_col`, strobed by `col`. It sits between the frame source (camera/DMA reader) and the systolic array in the driver-monitoring conv pipeline.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_column_feeder_if.sv | 24 ++
 rtl/conv_column_feeder_line_buffer.sv | 23 ++
 rtl/conv_column_feeder.sv | 131 +++++++++++++
 tb/tb_conv_column_feeder.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv column feeder and the systolic array that consumes its columns.
package conv_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int IMG_WIDTH_DEF  = 224;
   localparam int IMG_HEIGHT_DEF = 224;

   // Column packing: row y-2 sits in the most significant slice.
   localparam int COL_ROWS     = 3;
   localparam int COL_SLICE_Y2 = 2;
   localparam int COL_SLICE_Y1 = 1;
   localparam int COL_SLICE_Y0 = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } feeder_state_e;

endpackage

// File: rtl/conv_column_feeder_if.sv
// Pixel-in / column-out signal bundle of the column feeder.
interface conv_column_feeder_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0]                    pix_in;
   logic                                     pix_valid;
   logic                                     pix_sof;
   logic                                     pix_ready;
   logic                                     col;
   logic [conv_pkg::COL_ROWS*DATA_WIDTH-1:0] input_col;
   logic                                     row_last;
   logic                                     frame_done;
   logic                                     frame_err;

   modport master (
      output pix_in, pix_valid, pix_sof,
      input  pix_ready, col, input_col, row_last, frame_done, frame_err
   );

   modport slave (
      input  pix_in, pix_valid, pix_sof,
      output pix_ready, col, input_col, row_last, frame_done, frame_err
   );
endinterface

// File: rtl/conv_column_feeder_line_buffer.sv
// One image row of storage: combinational read, synchronous write at the same address.
module line_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 224
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   output logic [DATA_WIDTH-1:0]    rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/conv_column_feeder.sv
// Turns a raster pixel stream into 3-row vertical columns for the 3x3 systolic array.
//
// state  | meaning
// IDLE   | waiting for a pixel flagged start-of-frame; other pixels are dropped
// FILL   | rows 0 and 1 loading into the line buffers, no columns yet
// STREAM | row 2 onward, one column per accepted pixel
// DONE   | one cycle after the final accept, frame_done follows next cycle
module conv_column_feeder
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   conv_column_feeder_if.slave bus
);

   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

   feeder_state_e state, state_nxt;
   logic [XW-1:0] x, x_nxt, lb_addr;
   logic [YW-1:0] y, y_nxt;
   logic          accept, lb_we, col_en, err_en;
   logic          ready_q, col_q, row_last_q, frame_done_q, frame_err_q;
   logic [COL_ROWS*DATA_WIDTH-1:0] input_col_q;
   logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;

   assign accept = bus.pix_valid && ready_q;

   line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb0 (
      .clk   (clk),
      .we    (lb_we),
      .addr  (lb_addr),
      .wdata (bus.pix_in),
      .rdata (lb0_rd)
   );

   line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
      .clk   (clk),
      .we    (lb_we),
      .addr  (lb_addr),
      .wdata (lb0_rd),
      .rdata (lb1_rd)
   );

   always_comb begin
      state_nxt = state;
      x_nxt     = x;
      y_nxt     = y;
      lb_we     = 1'b0;
      lb_addr   = x;
      col_en    = 1'b0;
      err_en    = 1'b0;
      unique case (state)
         IDLE, FILL, STREAM: begin
            if (accept) begin
               if (bus.pix_sof) begin
                  // Any start-of-frame restarts at (0,0); mid-frame it also flags an error.
                  lb_we     = 1'b1;
                  lb_addr   = '0;
                  x_nxt     = XW'(1);
                  y_nxt     = '0;
                  state_nxt = FILL;
                  err_en    = (state != IDLE);
               end else if (state != IDLE) begin
                  lb_we  = 1'b1;
                  col_en = (state == STREAM);
                  if (x == X_LAST) begin
                     x_nxt = '0;
                     if (y == Y_LAST) begin
                        y_nxt     = '0;
                        state_nxt = DONE;
                     end else begin
                        y_nxt = y + YW'(1);
                        if (y == YW'(1)) begin
                           state_nxt = STREAM;
                        end
                     end
                  end else begin
                     x_nxt = x + XW'(1);
                  end
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         x            <= '0;
         y            <= '0;
         ready_q      <= 1'b0;
         col_q        <= 1'b0;
         row_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         input_col_q  <= '0;
      end else begin
         state        <= state_nxt;
         x            <= x_nxt;
         y            <= y_nxt;
         // Ready drops while entering DONE and stays low through the frame_done cycle.
         ready_q      <= (state_nxt != DONE) && (state != DONE);
         col_q        <= col_en;
         row_last_q   <= col_en && (x == X_LAST);
         frame_done_q <= (state == DONE);
         frame_err_q  <= err_en;
         if (col_en) begin
            input_col_q[COL_SLICE_Y2*DATA_WIDTH +: DATA_WIDTH] <= lb1_rd;
            input_col_q[COL_SLICE_Y1*DATA_WIDTH +: DATA_WIDTH] <= lb0_rd;
            input_col_q[COL_SLICE_Y0*DATA_WIDTH +: DATA_WIDTH] <= bus.pix_in;
         end
      end
   end

   assign bus.pix_ready  = ready_q;
   assign bus.col        = col_q;
   assign bus.input_col  = input_col_q;
   assign bus.row_last   = row_last_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_conv_column_feeder.sv
// Directed bench for the column feeder on a 4x4 image, pixel value = base + 16*y + x.
module tb_conv_column_feeder;

   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int n_cmp   = 0;
   int n_bad   = 0;
   int col_cnt = 0;
   int fd_cnt  = 0;
   int err_cnt = 0;

   conv_column_feeder_if #(.DATA_WIDTH(DW)) bus ();

   conv_column_feeder #(
      .DATA_WIDTH (DW),
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit v, input bit s, input int px, input int py,
                       input int base, input bit exp_col);
      logic [23:0] exp_data;
      bus.pix_valid = v;
      bus.pix_sof   = s;
      bus.pix_in    = 8'(base + 16*py + px);
      @(posedge clk);
      #1;
      chk("col", 32'(bus.col), 32'(exp_col));
      if (exp_col) begin
         exp_data = {8'(base + 16*(py-2) + px), 8'(base + 16*(py-1) + px), 8'(base + 16*py + px)};
         chk("input_col", 32'(bus.input_col), 32'(exp_data));
         chk("row_last", 32'(bus.row_last), 32'(px == W-1));
      end
      col_cnt += int'(bus.col);
      fd_cnt  += int'(bus.frame_done);
      err_cnt += int'(bus.frame_err);
   endtask

   task automatic send_pixels(input int first, input int last, input int base, input bit gaps);
      for (int i = first; i <= last; i++) begin
         int px;
         int py;
         px = i % W;
         py = i / W;
         if (gaps && ((px + 2*py) % 3 == 0)) begin
            step(1'b0, 1'b0, 0, 0, base, 1'b0);
            if (px == 2) step(1'b0, 1'b0, 0, 0, base, 1'b0);
         end
         step(1'b1, i == 0, px, py, base, py >= 2);
      end
   endtask

   task automatic frame_tail();
      chk("ready_in_done", 32'(bus.pix_ready), 32'd0);
      chk("fd_with_last_col", 32'(bus.frame_done), 32'd0);
      step(1'b0, 1'b0, 0, 0, 0, 1'b0);
      chk("frame_done_pulse", 32'(bus.frame_done), 32'd1);
      chk("ready_at_fd", 32'(bus.pix_ready), 32'd0);
      step(1'b0, 1'b0, 0, 0, 0, 1'b0);
      chk("frame_done_end", 32'(bus.frame_done), 32'd0);
      chk("ready_back", 32'(bus.pix_ready), 32'd1);
   endtask

   initial begin
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      bus.pix_in    = '0;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_col", 32'(bus.col), 32'd0);
      chk("rst_input_col", 32'(bus.input_col), 32'd0);
      chk("rst_row_last", 32'(bus.row_last), 32'd0);
      chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
      chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
      chk("rst_ready", 32'(bus.pix_ready), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_rst", 32'(bus.pix_ready), 32'd1);

      // Pixels without sof in IDLE are dropped, including ones that look like row 2.
      col_cnt = 0;
      step(1'b1, 1'b0, 1, 0, 0, 1'b0);
      step(1'b1, 1'b0, 2, 1, 0, 1'b0);
      step(1'b1, 1'b0, 3, 2, 0, 1'b0);
      chk("idle_discard_cols", col_cnt, 0);

      // Continuous full frame.
      col_cnt = 0; fd_cnt = 0; err_cnt = 0;
      send_pixels(0, 15, 0, 1'b0);
      frame_tail();
      chk("full_cols", col_cnt, 8);
      chk("full_fd", fd_cnt, 1);
      chk("full_err", err_cnt, 0);

      // Same frame with valid gaps.
      col_cnt = 0; fd_cnt = 0;
      send_pixels(0, 15, 0, 1'b1);
      frame_tail();
      chk("gap_cols", col_cnt, 8);
      chk("gap_fd", fd_cnt, 1);

      // sof at (2,3) aborts a frame; restarted frame uses base 0.
      col_cnt = 0; fd_cnt = 0; err_cnt = 0;
      send_pixels(0, 13, 8'h80, 1'b0);
      step(1'b1, 1'b1, 0, 0, 0, 1'b0);
      chk("frame_err_pulse", 32'(bus.frame_err), 32'd1);
      chk("no_partial_fd", fd_cnt, 0);
      send_pixels(1, 15, 0, 1'b0);
      frame_tail();
      chk("restart_cols", col_cnt, 14);
      chk("restart_err", err_cnt, 1);
      chk("restart_fd", fd_cnt, 1);

      // Reset in STREAM just after the (1,2) column.
      send_pixels(0, 9, 8'h40, 1'b0);
      rst_n         = 1'b0;
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      #1;
      chk("arst_col", 32'(bus.col), 32'd0);
      chk("arst_input_col", 32'(bus.input_col), 32'd0);
      chk("arst_row_last", 32'(bus.row_last), 32'd0);
      chk("arst_frame_done", 32'(bus.frame_done), 32'd0);
      chk("arst_frame_err", 32'(bus.frame_err), 32'd0);
      chk("arst_ready", 32'(bus.pix_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_arst", 32'(bus.pix_ready), 32'd1);
      col_cnt = 0; fd_cnt = 0;
      send_pixels(0, 15, 8'h10, 1'b0);
      frame_tail();
      chk("post_rst_cols", col_cnt, 8);
      chk("post_rst_fd", fd_cnt, 1);

      // Two frames back to back with distinct pixel values.
      col_cnt = 0; fd_cnt = 0; err_cnt = 0;
      send_pixels(0, 15, 8'h20, 1'b0);
      frame_tail();
      send_pixels(0, 15, 8'hA0, 1'b0);
      frame_tail();
      chk("b2b_cols", col_cnt, 16);
      chk("b2b_fd", fd_cnt, 2);
      chk("b2b_err", err_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "time limit");
   end

endmodule
